varint_writer: RTL and testbench

- Upstream stage of the memcpy engine in the protobuf serializer.
- Encodes one 64-bit field value (tag or scalar payload) as a protobuf base-128 varint.
- Writes the 1–10 encoded bytes to DRAM at dst through the same 8-lane byte port the memcpy engine uses.
- Reports the encoded length so the sequencer can advance the output cursor before launching the next varint or memcpy.

---
 rtl/varint_writer.sv | 148 ++++++++++++++
 tb/tb_varint_writer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/varint_writer.sv
// Protobuf base-128 varint encoder writing 1..10 bytes through the 8-lane DRAM byte port.
// Optional sint64 zigzag pre-transform is built only when VARINT_WRITER_ZIGZAG_EN is defined.
module varint_writer #(
  parameter int LANES  = 8,
  parameter int ADDR_W = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic [63:0]                    value,
  input  logic [ADDR_W-1:0]              dst,
  input  logic                           zigzag,
  output logic                           done,
  output logic [3:0]                     length,
  output logic [LANES-1:0]               dram_en,
  output logic                           dram_rdwr,
  output logic [LANES-1:0][ADDR_W-1:0]   dram_addr,
  output logic [LANES-1:0][7:0]          dram_data_out,
  input  logic [LANES-1:0]               dram_valid
);

  typedef enum logic [2:0] {S_IDLE, S_ENC, S_WR0, S_WR1, S_DONE} state_t;

  state_t                 r_state;
  logic [63:0]            r_v;
  logic [ADDR_W-1:0]      r_dst;
  logic [9:0][7:0]        r_bytes;
  logic [3:0]             r_len;
  logic [LANES-1:0]       r_pend;
  logic                   r_done;
  logic [3:0]             r_length;

  logic [63:0]            w_v_in;
  logic [3:0]             w_len;
  logic [9:0][7:0]        w_bytes;
  logic [LANES-1:0]       w_mask0;
  logic [LANES-1:0]       w_mask1;
  logic [LANES-1:0]       w_left;
  logic [LANES-1:0][7:0]  w_hi;

`ifdef VARINT_WRITER_ZIGZAG_EN
  assign w_v_in = zigzag ? ((value << 1) ^ {64{value[63]}}) : value;
`else
  logic w_unused_zigzag;
  assign w_unused_zigzag = zigzag;
  assign w_v_in = value;
`endif

  // Length is the index of the highest non-empty 7-bit group, plus one.
  always_comb begin
    w_len = 4'd1;
    for (int k = 1; k < 10; k++) begin
      if ((r_v >> (7 * k)) != 64'd0) w_len = 4'(k + 1);
    end
  end

  always_comb begin
    w_bytes = '0;
    for (int k = 0; k < 9; k++) begin
      w_bytes[k] = {(4'(k) < (w_len - 4'd1)), r_v[7*k +: 7]};
    end
    w_bytes[9] = {7'd0, r_v[63]};
  end

  assign w_mask0 = (w_len >= 4'd8) ? '1 : LANES'((1 << w_len) - 1);
  assign w_mask1 = LANES'((1 << (r_len - 4'd8)) - 1);
  assign w_left  = r_pend & ~dram_valid;

  always_comb begin
    w_hi    = '0;
    w_hi[0] = r_bytes[8];
    w_hi[1] = r_bytes[9];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_v      <= '0;
      r_dst    <= '0;
      r_bytes  <= '0;
      r_len    <= '0;
      r_pend   <= '0;
      r_done   <= 1'b0;
      r_length <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (en) begin
            r_v     <= w_v_in;
            r_dst   <= dst;
            r_done  <= 1'b0;
            r_state <= S_ENC;
          end
        end
        S_ENC: begin
          r_bytes <= w_bytes;
          r_len   <= w_len;
          r_pend  <= w_mask0;
          r_state <= S_WR0;
        end
        S_WR0, S_WR1: begin
          r_pend <= w_left;
          if (w_left == '0) begin
            if (r_state == S_WR0 && r_len > 4'd8) begin
              r_pend  <= w_mask1;
              r_state <= S_WR1;
            end else begin
              r_done   <= 1'b1;
              r_length <= r_len;
              r_state  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (!en) begin
            r_done   <= 1'b0;
            r_length <= '0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dram_en   = r_pend;
  assign dram_rdwr = |r_pend;
  assign done      = r_done;
  assign length    = r_length;

  // Lanes outside the pending mask stay quiet so the shared port sees no stray data.
  always_comb begin
    dram_addr     = '0;
    dram_data_out = '0;
    for (int i = 0; i < LANES; i++) begin
      if (r_pend[i]) begin
        if (r_state == S_WR1) begin
          dram_addr[i]     = r_dst + ADDR_W'(8 + i);
          dram_data_out[i] = w_hi[i];
        end else begin
          dram_addr[i]     = r_dst + ADDR_W'(i);
          dram_data_out[i] = r_bytes[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_varint_writer.sv
// Self-checking bench for varint_writer: DRAM responder model with per-lane ack delays
// and a scoreboard of expected encodings built by an independent shift-by-7 model.
`timescale 1ns/1ps
module tb_varint_writer;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              en = 1'b0;
  logic              zigzag = 1'b0;
  logic [63:0]       value = '0;
  logic [63:0]       dst = '0;
  logic              done;
  logic [3:0]        length;
  logic [7:0]        dram_en;
  logic              dram_rdwr;
  logic [7:0][63:0]  dram_addr;
  logic [7:0][7:0]   dram_data_out;
  logic [7:0]        dram_valid = '0;

  typedef struct {
    logic [63:0] addr;
    int          len;
    logic [7:0]  b[10];
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mem [logic [63:0]];
  int          dly[8] = '{default: 0};
  int          cnt[8] = '{default: 0};
  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  seen;
  logic        hit_hi;

  always #5 clk = ~clk;

  varint_writer #(.LANES(8), .ADDR_W(64)) dut (
    .clk(clk), .reset(reset), .en(en), .value(value), .dst(dst), .zigzag(zigzag),
    .done(done), .length(length), .dram_en(dram_en), .dram_rdwr(dram_rdwr),
    .dram_addr(dram_addr), .dram_data_out(dram_data_out), .dram_valid(dram_valid)
  );

  // DRAM responder: a lane is acknowledged (and its byte stored) dly[i] cycles after request.
  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (!reset || !dram_en[i]) begin
        dram_valid[i] = 1'b0;
        cnt[i] = 0;
      end else if (cnt[i] >= dly[i]) begin
        mem[dram_addr[i]] = dram_data_out[i];
        dram_valid[i] = 1'b1;
        cnt[i] = 0;
      end else begin
        dram_valid[i] = 1'b0;
        cnt[i] = cnt[i] + 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500us");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : 8'hEE;
  endfunction

  function automatic exp_t model(input logic [63:0] val, input logic zz);
    exp_t m;
    logic [63:0] v;
    v = val;
`ifdef VARINT_WRITER_ZIGZAG_EN
    if (zz) v = (val << 1) ^ {64{val[63]}};
`else
    if (zz) v = val;
`endif
    m.addr = '0;
    m.len = 0;
    foreach (m.b[k]) m.b[k] = 8'hEE;
    do begin
      m.b[m.len] = {v > 64'h7F, v[6:0]};
      v = v >> 7;
      m.len++;
    end while (v != 64'd0);
    return m;
  endfunction

  task automatic set_dly(input int d);
    for (int i = 0; i < 8; i++) dly[i] = d;
  endtask

  task automatic run(input string tag, input logic [63:0] val, input logic [63:0] d, input logic zz);
    exp_t e;
    e = model(val, zz);
    e.addr = d;
    sb.push_back(e);
    mem.delete();
    seen = '0;
    hit_hi = 1'b0;
    @(negedge clk);
    value = val; dst = d; zigzag = zz; en = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      seen |= dram_en;
      if (dram_en[1] && dram_addr[1] == d + 64'd9) hit_hi = 1'b1;
      if (e.len <= 8 && (dram_valid & dram_en) != 8'h00)
        chk({tag, "_lane_drop"}, 64'(dram_valid & dram_en), 64'h0);
      if (done) break;
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
    e = sb.pop_front();
    chk({tag, "_length"}, 64'(length), 64'(e.len));
    for (int k = 0; k < 10; k++)
      chk($sformatf("%s_byte%0d", tag, k), 64'(rd(e.addr + 64'(k))), 64'(e.b[k]));
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_hold"}, 64'(done), 64'd1);
    chk({tag, "_idle_lanes"}, 64'(dram_en), 64'h0);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_done_clear"}, 64'(done), 64'd0);
  endtask

  initial begin
    exp_t er;
    #2 reset = 1'b0;
    #1;
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_length", 64'(length), 64'd0);
    chk("rst_en", 64'(dram_en), 64'h0);
    chk("rst_rdwr", 64'(dram_rdwr), 64'd0);
    chk("rst_addr0", dram_addr[0], 64'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    run("v0", 64'd0, 64'h3FF, 1'b0);
    chk("v0_only_lane0", 64'(seen), 64'h01);
    run("v300", 64'd300, 64'h200, 1'b0);
    run("v127", 64'd127, 64'h200, 1'b0);
    run("v128", 64'd128, 64'h200, 1'b0);
    run("vmax", 64'hFFFF_FFFF_FFFF_FFFF, 64'h200, 1'b0);
    chk("vmax_lanes", 64'(seen), 64'hFF);
    chk("vmax_wr1_lane1_addr", 64'(hit_hi), 64'd1);
    run("vwrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);

    for (int i = 0; i < 8; i++) dly[i] = 5 * (7 - i);
    run("ooo", 64'h00FF_FFFF_FFFF_FFFF, 64'h400, 1'b0);
    set_dly(0);

    // Reset in the middle of the second burst.
    set_dly(3);
    mem.delete();
    er = model(64'h8000_0000_0000_0000, 1'b0);
    @(negedge clk);
    value = 64'h8000_0000_0000_0000; dst = 64'h1000; zigzag = 1'b0; en = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (dram_en == 8'h03 && dram_addr[0] == 64'h1008) break;
    end
    chk("rst_wr1_reached", dram_addr[0], 64'h1008);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_en", 64'(dram_en), 64'h0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_rdwr", 64'(dram_rdwr), 64'd0);
    for (int k = 0; k < 10; k++)
      chk($sformatf("midrst_mem%0d", k), 64'(rd(64'h1000 + 64'(k))), (k < 8) ? 64'(er.b[k]) : 64'hEE);
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    set_dly(0);
    run("postrst", 64'h8000_0000_0000_0000, 64'h1000, 1'b0);

    run("zz_m1", 64'hFFFF_FFFF_FFFF_FFFF, 64'h300, 1'b1);
    run("zz_p1", 64'd1, 64'h300, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
